// File: rtl/nios_system_cpu_1_oci_dct_packer_if.sv
// Handshake bundle between the trace source/frame consumer and the DCT packer.
// The master side drives codes and control; the slave side is the packer.
interface nios_system_cpu_1_oci_dct_packer_if;
    logic        trace_valid;
    logic [1:0]  trace_code;
    logic        trace_ready;
    logic        flush;
    logic        end_req;
    logic        frame_valid;
    logic        frame_ready;
    logic [29:0] frame_data;
    logic [3:0]  frame_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;

    modport master (
        output trace_valid,
        output trace_code,
        output flush,
        output end_req,
        output frame_ready,
        input  trace_ready,
        input  frame_valid,
        input  frame_data,
        input  frame_count,
        input  dct_buffer,
        input  dct_count,
        input  test_ending,
        input  test_has_ended
    );

    modport slave (
        input  trace_valid,
        input  trace_code,
        input  flush,
        input  end_req,
        input  frame_ready,
        output trace_ready,
        output frame_valid,
        output frame_data,
        output frame_count,
        output dct_buffer,
        output dct_count,
        output test_ending,
        output test_has_ended
    );
endinterface

// File: rtl/nios_system_cpu_1_oci_dct_packer.sv
// Packs 2-bit data-trace codes into 30-bit frames; full frames and flushes go to a one-deep frame register.
// Latency: a code or flush reaches the frame register on the edge it is accepted (if the register is free).
// Backpressure: trace_ready drops when the next code would complete a frame that has nowhere to go.
module nios_system_cpu_1_oci_dct_packer #(
    parameter int FULL_COUNT = 15
) (
    input  logic                                clk,
    input  logic                                reset,
    nios_system_cpu_1_oci_dct_packer_if.slave   pif
);

    localparam logic [3:0] FULL_CNT = 4'(FULL_COUNT);
    localparam logic [3:0] LAST_CNT = 4'(FULL_COUNT - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [29:0] buf_q;
    logic [3:0]  cnt_q;
    logic        fv_q;
    logic [29:0] fd_q;
    logic [3:0]  fc_q;
    logic        fp_q;
    logic        te_q;

    logic        trace_ready_c;
    logic        accept;
    logic [29:0] buf_pk;
    logic [3:0]  cnt_pk;
    logic        full_load;
    logic        flush_req;
    logic        fp_now;
    logic        frame_free;
    logic        flush_load;
    logic        load_frame;

    // A held frame blocks only the code that would complete the next frame,
    // and any code once a flush is waiting so the flushed content stays fixed.
    always_comb begin
        trace_ready_c = 1'b1;
        if (state != ST_RUN) begin
            trace_ready_c = 1'b0;
        end else if (fv_q && (cnt_q == LAST_CNT)) begin
            trace_ready_c = 1'b0;
        end else if (fv_q && fp_q) begin
            trace_ready_c = 1'b0;
        end
    end

    always_comb begin
        accept     = pif.trace_valid && trace_ready_c;
        buf_pk     = accept ? {buf_q[27:0], pif.trace_code} : buf_q;
        cnt_pk     = cnt_q + (accept ? 4'd1 : 4'd0);
        full_load  = accept && (cnt_pk == FULL_CNT);
        flush_req  = (state == ST_RUN) && (pif.flush || pif.end_req);
        // The code packed this cycle joins any flush requested alongside it.
        fp_now     = fp_q || (flush_req && (cnt_pk != 4'd0) && !full_load);
        frame_free = !fv_q || pif.frame_ready;
        flush_load = fp_now && frame_free && !full_load;
        load_frame = full_load || flush_load;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (pif.end_req) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((cnt_q == 4'd0) && !fp_q && frame_free) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q <= '0;
            cnt_q <= '0;
            fp_q  <= 1'b0;
        end else if (load_frame) begin
            buf_q <= '0;
            cnt_q <= '0;
            fp_q  <= 1'b0;
        end else begin
            buf_q <= buf_pk;
            cnt_q <= cnt_pk;
            fp_q  <= fp_now;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fv_q <= 1'b0;
            fd_q <= '0;
            fc_q <= '0;
        end else if (load_frame) begin
            fv_q <= 1'b1;
            fd_q <= buf_pk;
            fc_q <= cnt_pk;
        end else if (fv_q && pif.frame_ready) begin
            fv_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            te_q <= 1'b0;
        end else begin
            te_q <= (state == ST_RUN) && pif.end_req;
        end
    end

    assign pif.trace_ready    = trace_ready_c;
    assign pif.frame_valid    = fv_q;
    assign pif.frame_data     = fd_q;
    assign pif.frame_count    = fc_q;
    assign pif.dct_buffer     = buf_q;
    assign pif.dct_count      = cnt_q;
    assign pif.test_ending    = te_q;
    assign pif.test_has_ended = (state == ST_DONE);

endmodule

// File: tb/tb_nios_system_cpu_1_oci_dct_packer.sv
// Directed bench for the DCT packer: full frames, flushes, backpressure, end of capture and reset.
module tb_nios_system_cpu_1_oci_dct_packer;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    nios_system_cpu_1_oci_dct_packer_if pif();

    nios_system_cpu_1_oci_dct_packer #(.FULL_COUNT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .pif   (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    a_cnt_bound: assert property (@(posedge clk) disable iff (reset) pif.dct_count <= 4'd15)
        else $error("FAIL dct_count_bound got %0d limit 15", pif.dct_count);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] code);
        pif.trace_valid = 1'b1;
        pif.trace_code  = code;
        tick();
        pif.trace_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        pif.flush = 1'b1;
        tick();
        pif.flush = 1'b0;
    endtask

    task automatic pulse_end();
        pif.end_req = 1'b1;
        tick();
        pif.end_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [29:0] exp1;
    logic [29:0] exp2;
    logic [29:0] exp_buf;

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        reset            = 1'b1;
        pif.trace_valid  = 1'b0;
        pif.trace_code   = 2'd0;
        pif.flush        = 1'b0;
        pif.end_req      = 1'b0;
        pif.frame_ready  = 1'b1;
        do_reset();

        // Reset state
        chk("rst_dct_count",   32'(pif.dct_count),      32'd0);
        chk("rst_dct_buffer",  32'(pif.dct_buffer),     32'd0);
        chk("rst_frame_valid", 32'(pif.frame_valid),    32'd0);
        chk("rst_frame_data",  32'(pif.frame_data),     32'd0);
        chk("rst_frame_count", 32'(pif.frame_count),    32'd0);
        chk("rst_trace_ready", 32'(pif.trace_ready),    32'd1);
        chk("rst_test_ending", 32'(pif.test_ending),    32'd0);
        chk("rst_has_ended",   32'(pif.test_has_ended), 32'd0);

        // Full frame of fifteen 01 codes
        for (int i = 0; i < 14; i++) send(2'b01);
        chk("full_pre_count",  32'(pif.dct_count),  32'd14);
        chk("full_pre_buffer", 32'(pif.dct_buffer), 32'h0555_5555);
        chk("full_pre_fv",     32'(pif.frame_valid), 32'd0);
        send(2'b01);
        chk("full_fv",    32'(pif.frame_valid), 32'd1);
        chk("full_data",  32'(pif.frame_data),  32'h1555_5555);
        chk("full_count", 32'(pif.frame_count), 32'd15);
        chk("full_dct0",  32'(pif.dct_count),   32'd0);
        tick();
        chk("full_fv_1cyc", 32'(pif.frame_valid), 32'd0);

        // Flush of a partial buffer, then an empty flush
        send(2'd3);
        send(2'd2);
        send(2'd1);
        pulse_flush();
        chk("flush_fv",    32'(pif.frame_valid), 32'd1);
        chk("flush_data",  32'(pif.frame_data),  32'h0000_0039);
        chk("flush_count", 32'(pif.frame_count), 32'd3);
        chk("flush_dct0",  32'(pif.dct_count),   32'd0);
        tick();
        chk("flush_consumed", 32'(pif.frame_valid), 32'd0);
        pulse_flush();
        chk("flush_empty_fv", 32'(pif.frame_valid), 32'd0);

        // Accept and flush in the same cycle
        send(2'd0);
        send(2'd1);
        send(2'd2);
        send(2'd3);
        pif.trace_valid = 1'b1;
        pif.trace_code  = 2'd2;
        pif.flush       = 1'b1;
        tick();
        pif.trace_valid = 1'b0;
        pif.flush       = 1'b0;
        chk("simul_count", 32'(pif.frame_count),     32'd5);
        chk("simul_lsb",   32'(pif.frame_data[1:0]), 32'd2);
        chk("simul_data",  32'(pif.frame_data),      32'h0000_006E);
        tick();

        // Backpressure: frame register held while the buffer refills
        exp1 = '0;
        for (int i = 0; i < 15; i++) exp1 = {exp1[27:0], 2'(i)};
        exp_buf = '0;
        for (int i = 15; i < 29; i++) exp_buf = {exp_buf[27:0], 2'(i)};
        exp2 = {exp_buf[27:0], 2'(29)};
        pif.frame_ready = 1'b0;
        for (int i = 0; i < 29; i++) send(2'(i));
        chk("bp_ready",  32'(pif.trace_ready), 32'd0);
        chk("bp_count",  32'(pif.dct_count),   32'd14);
        chk("bp_buffer", 32'(pif.dct_buffer),  32'(exp_buf));
        chk("bp_fv",     32'(pif.frame_valid), 32'd1);
        tick();
        tick();
        chk("bp_hold_data",  32'(pif.frame_data),  32'(exp1));
        chk("bp_hold_count", 32'(pif.frame_count), 32'd15);
        chk("bp_hold_fv",    32'(pif.frame_valid), 32'd1);
        pif.frame_ready = 1'b1;
        tick();
        chk("bp_released_fv",    32'(pif.frame_valid), 32'd0);
        chk("bp_released_ready", 32'(pif.trace_ready), 32'd1);
        send(2'(29));
        chk("bp_f2_fv",    32'(pif.frame_valid), 32'd1);
        chk("bp_f2_data",  32'(pif.frame_data),  32'(exp2));
        chk("bp_f2_count", 32'(pif.frame_count), 32'd15);
        chk("bp_f2_dct0",  32'(pif.dct_count),   32'd0);
        tick();

        // End of capture with two codes buffered
        send(2'd1);
        send(2'd2);
        pulse_end();
        chk("end_pulse",  32'(pif.test_ending), 32'd1);
        chk("end_fv",     32'(pif.frame_valid), 32'd1);
        chk("end_count",  32'(pif.frame_count), 32'd2);
        chk("end_data",   32'(pif.frame_data),  32'h0000_0006);
        chk("end_ready0", 32'(pif.trace_ready), 32'd0);
        tick();
        chk("end_pulse_1cyc", 32'(pif.test_ending),    32'd0);
        chk("end_has_ended",  32'(pif.test_has_ended), 32'd1);
        chk("end_fv_clear",   32'(pif.frame_valid),    32'd0);
        pif.trace_valid = 1'b1;
        pif.flush       = 1'b1;
        pif.end_req     = 1'b1;
        tick();
        tick();
        pif.trace_valid = 1'b0;
        pif.flush       = 1'b0;
        pif.end_req     = 1'b0;
        chk("done_sticky", 32'(pif.test_has_ended), 32'd1);
        chk("done_ready",  32'(pif.trace_ready),    32'd0);
        chk("done_dct",    32'(pif.dct_count),      32'd0);
        chk("done_fv",     32'(pif.frame_valid),    32'd0);
        chk("done_pulse",  32'(pif.test_ending),    32'd0);

        // Reset while draining with a held frame
        do_reset();
        chk("rst2_has_ended", 32'(pif.test_has_ended), 32'd0);
        chk("rst2_ready",     32'(pif.trace_ready),    32'd1);
        pif.frame_ready = 1'b0;
        send(2'd3);
        send(2'd3);
        pulse_end();
        tick();
        chk("drain_fv",      32'(pif.frame_valid),    32'd1);
        chk("drain_not_done", 32'(pif.test_has_ended), 32'd0);
        reset = 1'b1;
        tick();
        chk("rst3_fv",        32'(pif.frame_valid),    32'd0);
        chk("rst3_fd",        32'(pif.frame_data),     32'd0);
        chk("rst3_fc",        32'(pif.frame_count),    32'd0);
        chk("rst3_dct",       32'(pif.dct_count),      32'd0);
        chk("rst3_buf",       32'(pif.dct_buffer),     32'd0);
        chk("rst3_ending",    32'(pif.test_ending),    32'd0);
        chk("rst3_has_ended", 32'(pif.test_has_ended), 32'd0);
        chk("rst3_ready",     32'(pif.trace_ready),    32'd1);
        reset = 1'b0;
        send(2'd2);
        chk("rst3_run_count", 32'(pif.dct_count),  32'd1);
        chk("rst3_run_buf",   32'(pif.dct_buffer), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
